// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the sequential shifter.
// Contents: shift_mode_t (operation codes), shift_state_t (control states),
// MODE_W (mode field width) and is_shift_mode() (true for modes that move bits).
package shifter_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ModePass  = 3'b000,
    ModeLsl   = 3'b001,
    ModeLsr   = 3'b010,
    ModeRol   = 3'b011,
    ModeRor   = 3'b100,
    ModeAsr   = 3'b101,
    ModeRsvd6 = 3'b110,
    ModeRsvd7 = 3'b111
  } shift_mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } shift_state_t;

  // Pass and the reserved codes leave the operand untouched.
  function automatic logic is_shift_mode(logic [MODE_W-1:0] mode);
    logic res;
    case (mode)
      ModeLsl, ModeLsr, ModeRol, ModeRor, ModeAsr: res = 1'b1;
      default:                                     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle of the sequential shifter.
// Signals: start, mode, amount, data_in (requester -> shifter);
//          data_out, busy, done (shifter -> requester).
// Modports: master = requester side, slave = shifter side.
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
);

  logic                            start;
  logic [shifter_pkg::MODE_W-1:0]  mode;
  logic [AMT_W-1:0]                amount;
  logic [WIDTH-1:0]                data_in;
  logic [WIDTH-1:0]                data_out;
  logic                            busy;
  logic                            done;

  modport master (
    output start, mode, amount, data_in,
    input  data_out, busy, done
  );

  modport slave (
    input  start, mode, amount, data_in,
    output data_out, busy, done
  );

endinterface

// File: rtl/seq_shifter_step.sv
// Single-bit shift/rotate step, purely combinational.
// Ports: mode (operation code), din (operand), dout (din moved by one bit).
// Pass and reserved codes return din unchanged.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  always_comb begin
    dout = din;
    case (mode)
      ModeLsl: dout = {din[WIDTH-2:0], 1'b0};
      ModeLsr: dout = {1'b0, din[WIDTH-1:1]};
      ModeRol: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      ModeRor: dout = {din[0], din[WIDTH-1:1]};
      // MSB is never changed by this step, so repeated steps keep copying the original MSB.
      ModeAsr: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shift unit: one single-bit step per clock with start/busy/done handshake.
// Ports: clk (rising-edge clock), reset (synchronous, active high),
//        bus (seq_shifter_if slave: start/mode/amount/data_in in, data_out/busy/done out).
// An accepted start loads the operand into the result register; SHIFT then steps it
// amount times through shift_step, and DONE raises done for one cycle.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  seq_shifter_if.slave  bus
);

  localparam logic [1:0] StateIdle  = StIdle;
  localparam logic [1:0] StateShift = StShift;
  localparam logic [1:0] StateDone  = StDone;

  logic [1:0]        state_q, state_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  step_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode (mode_q),
    .din  (data_q),
    .dout (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    case (state_q)
      StateIdle: begin
        if (bus.start) begin
          data_d = bus.data_in;
          cnt_d  = bus.amount;
          mode_d = bus.mode;
          if ((bus.amount != '0) && is_shift_mode(bus.mode)) begin
            state_d = StateShift;
          end else begin
            state_d = StateDone;
          end
        end
      end
      StateShift: begin
        data_d = step_out;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StateDone;
        end
      end
      StateDone: begin
        state_d = StateIdle;
      end
      default: begin
        state_d = StateIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StateIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.busy     = (state_q != StateIdle);
  assign bus.done     = (state_q == StateDone);

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;
  import shifter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_shifter_if #(.WIDTH(8),  .AMT_W(3)) if8 ();
  seq_shifter_if #(.WIDTH(16), .AMT_W(4)) if16 ();

  seq_shifter #(.WIDTH(8),  .AMT_W(3)) dut8  (.clk(clk), .reset(reset), .bus(if8));
  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut16 (.clk(clk), .reset(reset), .bus(if16));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit wide, input logic st, input logic [2:0] m,
                       input logic [3:0] a, input logic [15:0] d);
    if (wide) begin
      if16.start = st; if16.mode = m; if16.amount = a; if16.data_in = d;
    end else begin
      if8.start = st; if8.mode = m; if8.amount = a[2:0]; if8.data_in = d[7:0];
    end
  endtask

  task automatic sample(input bit wide, output logic b, output logic dn, output logic [15:0] q);
    if (wide) begin
      b = if16.busy; dn = if16.done; q = if16.data_out;
    end else begin
      b = if8.busy; dn = if8.done; q = {8'h00, if8.data_out};
    end
  endtask

  // Issues one operation from an IDLE cycle, reports the cycle of done (-1 on timeout),
  // the result, whether busy held throughout, and the state one cycle after done.
  task automatic run_op(input bit wide, input logic [2:0] m, input logic [3:0] a,
                        input logic [15:0] d, output int done_cyc, output logic [15:0] res,
                        output bit busy_all, output logic idle_busy, output logic [15:0] idle_q);
    logic b, dn;
    logic [15:0] q;
    drive(wide, 1'b1, m, a, d);
    done_cyc = -1;
    busy_all = 1'b1;
    res      = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) drive(wide, 1'b0, m, a, d);
      sample(wide, b, dn, q);
      if (!b) busy_all = 1'b0;
      if (dn) begin
        done_cyc = cyc;
        res      = q;
        break;
      end
    end
    @(posedge clk); #1;
    sample(wide, idle_busy, dn, idle_q);
  endtask

  function automatic logic [15:0] ref16(logic [2:0] m, logic [3:0] a, logic [15:0] d);
    logic [31:0]        dd;
    logic signed [15:0] s;
    logic [15:0]        r;
    dd = {d, d};
    s  = d;
    case (m)
      3'b001: r = d << a;
      3'b010: r = d >> a;
      3'b011: begin dd = dd << a; r = dd[31:16]; end
      3'b100: begin dd = dd >> a; r = dd[15:0]; end
      3'b101: r = s >>> a;
      default: r = d;
    endcase
    return r;
  endfunction

  initial begin
    int          dc;
    logic [15:0] r, iq, q;
    bit          ba;
    logic        ib, b, dn;
    logic [2:0]  m;
    logic [3:0]  a;
    logic [15:0] d;
    int          exp_lat;

    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 4'd0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 4'd0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst8_data", {24'h0, if8.data_out}, 32'h0);
    check_eq("rst8_busy", {31'h0, if8.busy}, 32'h0);
    check_eq("rst8_done", {31'h0, if8.done}, 32'h0);
    check_eq("rst16_data", {16'h0, if16.data_out}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of ROL 0xA5 by 3.
    drive(1'b0, 1'b1, 3'b011, 4'd3, 16'h00A5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b011, 4'd3, 16'h00A5);
    check_eq("midrst_busy_c1", {31'h0, if8.busy}, 32'h1);
    check_eq("midrst_done_c1", {31'h0, if8.done}, 32'h0);
    @(posedge clk); #1;
    check_eq("midrst_done_c2", {31'h0, if8.done}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_data", {24'h0, if8.data_out}, 32'h0);
    check_eq("midrst_busy", {31'h0, if8.busy}, 32'h0);
    check_eq("midrst_done", {31'h0, if8.done}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("postrst_done", {31'h0, if8.done}, 32'h0);
    check_eq("postrst_data", {24'h0, if8.data_out}, 32'h0);
    run_op(1'b0, 3'b011, 4'd3, 16'h00A5, dc, r, ba, ib, iq);
    check_eq("rol_lat", dc, 32'd4);
    check_eq("rol_res", r, 16'h002D);
    check_eq("rol_idle_busy", {31'h0, ib}, 32'h0);
    check_eq("rol_hold", iq, 16'h002D);

    // ASR 1001_0110 by 5.
    run_op(1'b0, 3'b101, 4'd5, 16'h0096, dc, r, ba, ib, iq);
    check_eq("asr_lat", dc, 32'd6);
    check_eq("asr_res", r, 16'h00FC);
    check_eq("asr_busy", {31'h0, ba}, 32'h1);
    check_eq("asr_idle_busy", {31'h0, ib}, 32'h0);

    run_op(1'b0, 3'b001, 4'd7, 16'h00FF, dc, r, ba, ib, iq);
    check_eq("lsl7_lat", dc, 32'd8);
    check_eq("lsl7_res", r, 16'h0080);
    run_op(1'b0, 3'b010, 4'd1, 16'h0081, dc, r, ba, ib, iq);
    check_eq("lsr1_lat", dc, 32'd2);
    check_eq("lsr1_res", r, 16'h0040);

    run_op(1'b0, 3'b100, 4'd0, 16'h003C, dc, r, ba, ib, iq);
    check_eq("ror0_lat", dc, 32'd1);
    check_eq("ror0_res", r, 16'h003C);
    run_op(1'b0, 3'b111, 4'd4, 16'h003C, dc, r, ba, ib, iq);
    check_eq("rsvd_lat", dc, 32'd1);
    check_eq("rsvd_res", r, 16'h003C);

    // ROR 0x01 by 4 with start held high and new operands every cycle.
    drive(1'b0, 1'b1, 3'b100, 4'd4, 16'h0001);
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e < 6) drive(1'b0, 1'b1, 3'b001, 4'd1, (e == 5) ? 16'h0055 : 16'(16'hF0 + e));
      else       drive(1'b0, 1'b0, 3'b001, 4'd1, 16'h0055);
      sample(1'b0, b, dn, q);
      if (e + 1 <= 4) check_eq("hold_nodone", {31'h0, dn}, 32'h0);
      if (e + 1 == 5) begin
        check_eq("hold_done", {31'h0, dn}, 32'h1);
        check_eq("hold_res", q, 16'h0010);
      end
      if (e + 1 == 6) begin
        check_eq("hold_idle_busy", {31'h0, b}, 32'h0);
        check_eq("hold_idle_data", q, 16'h0010);
      end
      if (e + 1 == 7) begin
        check_eq("hold_accept_busy", {31'h0, b}, 32'h1);
        check_eq("hold_accept_data", q, 16'h0055);
      end
    end
    @(posedge clk); #1;
    check_eq("hold_next_done", {31'h0, if8.done}, 32'h1);
    check_eq("hold_next_res", {24'h0, if8.data_out}, 32'h0000_00AA);
    @(posedge clk); #1;

    // 16-bit random sweep against the reference model.
    for (int i = 0; i < 1000; i++) begin
      m = 3'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      exp_lat = (is_shift_mode(m) && a != 4'd0) ? int'(a) + 1 : 1;
      run_op(1'b1, m, a, d, dc, r, ba, ib, iq);
      check_eq("rnd_lat", dc, exp_lat);
      check_eq("rnd_res", r, ref16(m, a, d));
      check_eq("rnd_idle", {31'h0, ib}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
